// File: rtl/drra_launch_sequencer.sv
// DRRA job sequencer: staggered column starts, ret collection, cycle count/timeout, irq and buffer lock.
// Define KTH_SS_SEQ_LOOP_EN to enable multi-pass jobs through the LOOP register at 0x14.
module drra_launch_sequencer #(
  parameter int N_COLS        = 2,
  parameter int CNT_W         = 32,
  parameter int LAUNCH_STRIDE = 1
) (
  input  logic              clk_in,
  input  logic              reset_int,
  input  logic              reg_we,
  input  logic [4:0]        reg_addr,
  input  logic [31:0]       reg_wdata,
  output logic [31:0]       reg_rdata,
  output logic [N_COLS-1:0] col_start,
  input  logic [N_COLS-1:0] col_ret,
  output logic              buf_lock,
  output logic              irq_3,
  output logic              irq_en_3
);
  localparam int GAP_W = (LAUNCH_STRIDE > 1) ? $clog2(LAUNCH_STRIDE) : 1;

  typedef enum logic [1:0] {S_IDLE, S_LAUNCH, S_RUN, S_DONE} state_t;

  state_t             state_q, state_d;
  logic               irq_en_q, irq_en_d;
  logic [N_COLS-1:0]  mask_q, mask_d;
  logic               done_q, done_d, tmo_flag_q, tmo_flag_d, abort_flag_q, abort_flag_d;
  logic [CNT_W-1:0]   cycles_q, cycles_d, tmo_q, tmo_d;
  logic [N_COLS-1:0]  ret_seen_q, ret_seen_d, pend_q, pend_d;
  logic [GAP_W-1:0]   gap_q, gap_d;
  logic               irq_q;
`ifdef KTH_SS_SEQ_LOOP_EN
  logic [7:0]         loop_q, loop_d, iter_q, iter_d;
`endif

  logic               wr_ctrl, wr_mask, wr_stat, wr_tmo;
  logic               start_req, abort_req, busy, active, tmo_hit, more_passes;
  logic [CNT_W-1:0]   cycles_inc;
  logic [N_COLS-1:0]  ret_all, pulse;
  logic               unused_bits;

  assign wr_ctrl   = reg_we && (reg_addr[4:2] == 3'd0);
  assign wr_mask   = reg_we && (reg_addr[4:2] == 3'd1);
  assign wr_stat   = reg_we && (reg_addr[4:2] == 3'd2);
  assign wr_tmo    = reg_we && (reg_addr[4:2] == 3'd4);
  // Abort in the same write as start cancels the start.
  assign start_req = wr_ctrl && reg_wdata[0] && !reg_wdata[1];
  assign abort_req = wr_ctrl && reg_wdata[1];

  assign busy       = (state_q != S_IDLE);
  assign active     = (state_q == S_LAUNCH) || (state_q == S_RUN);
  assign cycles_inc = (&cycles_q) ? cycles_q : cycles_q + CNT_W'(1);
  assign ret_all    = ret_seen_q | col_ret;
  // Compare against the count including this cycle so CYCLES ends equal to TIMEOUT.
  assign tmo_hit    = active && (tmo_q != '0) && (cycles_inc == tmo_q);
  assign pulse      = pend_q & (~pend_q + N_COLS'(1));
  assign col_start  = (state_q == S_LAUNCH && gap_q == '0) ? pulse : '0;
`ifdef KTH_SS_SEQ_LOOP_EN
  assign more_passes = (iter_q != 8'd0);
`else
  assign more_passes = 1'b0;
`endif

  assign buf_lock    = busy;
  assign irq_3       = irq_q;
  assign irq_en_3    = irq_en_q;
  assign unused_bits = ^{reg_wdata, reg_addr[1:0]};

  always_comb begin
    state_d      = state_q;
    irq_en_d     = irq_en_q;
    mask_d       = mask_q;
    done_d       = done_q;
    tmo_flag_d   = tmo_flag_q;
    abort_flag_d = abort_flag_q;
    cycles_d     = cycles_q;
    tmo_d        = tmo_q;
    ret_seen_d   = ret_seen_q;
    pend_d       = pend_q;
    gap_d        = gap_q;
`ifdef KTH_SS_SEQ_LOOP_EN
    loop_d       = loop_q;
    iter_d       = iter_q;
    if (reg_we && reg_addr[4:2] == 3'd5) loop_d = reg_wdata[7:0];
`endif
    if (wr_ctrl) irq_en_d = reg_wdata[2];
    if (wr_mask && !busy) mask_d = reg_wdata[N_COLS-1:0];
    if (wr_tmo) tmo_d = reg_wdata[CNT_W-1:0];
    if (wr_stat) begin
      done_d       = done_q & ~reg_wdata[1];
      tmo_flag_d   = tmo_flag_q & ~reg_wdata[2];
      abort_flag_d = abort_flag_q & ~reg_wdata[3];
    end

    case (state_q)
      S_IDLE: begin
        if (start_req && mask_q != '0) begin
          state_d    = S_LAUNCH;
          cycles_d   = '0;
          ret_seen_d = '0;
          pend_d     = mask_q;
          gap_d      = '0;
`ifdef KTH_SS_SEQ_LOOP_EN
          iter_d     = loop_q;
`endif
        end
      end
      S_LAUNCH, S_RUN: begin
        cycles_d   = cycles_inc;
        ret_seen_d = ret_all;
        if (state_q == S_LAUNCH) begin
          if (gap_q != '0) begin
            gap_d = gap_q - GAP_W'(1);
          end else begin
            pend_d = pend_q & ~pulse;
            gap_d  = GAP_W'(LAUNCH_STRIDE - 1);
            if ((pend_q & ~pulse) == '0) state_d = S_RUN;
          end
        end else if ((ret_all & mask_q) == mask_q) begin
          if (more_passes) begin
            state_d    = S_LAUNCH;
            ret_seen_d = '0;
            pend_d     = mask_q;
            gap_d      = '0;
`ifdef KTH_SS_SEQ_LOOP_EN
            iter_d     = iter_q - 8'd1;
`endif
          end else begin
            state_d = S_DONE;
          end
        end
        if (abort_req) begin
          state_d      = S_IDLE;
          abort_flag_d = 1'b1;
        end else if (tmo_hit) begin
          state_d    = S_IDLE;
          tmo_flag_d = 1'b1;
        end
      end
      S_DONE: begin
        done_d  = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_in) begin
    if (reset_int) begin
      state_q      <= S_IDLE;
      irq_en_q     <= 1'b0;
      mask_q       <= '0;
      done_q       <= 1'b0;
      tmo_flag_q   <= 1'b0;
      abort_flag_q <= 1'b0;
      cycles_q     <= '0;
      tmo_q        <= '0;
      ret_seen_q   <= '0;
      pend_q       <= '0;
      gap_q        <= '0;
      irq_q        <= 1'b0;
`ifdef KTH_SS_SEQ_LOOP_EN
      loop_q       <= '0;
      iter_q       <= '0;
`endif
    end else begin
      state_q      <= state_d;
      irq_en_q     <= irq_en_d;
      mask_q       <= mask_d;
      done_q       <= done_d;
      tmo_flag_q   <= tmo_flag_d;
      abort_flag_q <= abort_flag_d;
      cycles_q     <= cycles_d;
      tmo_q        <= tmo_d;
      ret_seen_q   <= ret_seen_d;
      pend_q       <= pend_d;
      gap_q        <= gap_d;
      irq_q        <= irq_en_q & (done_q | tmo_flag_q | abort_flag_q);
`ifdef KTH_SS_SEQ_LOOP_EN
      loop_q       <= loop_d;
      iter_q       <= iter_d;
`endif
    end
  end

  always_comb begin
    reg_rdata = '0;
    case (reg_addr[4:2])
      3'd0: reg_rdata[2]            = irq_en_q;
      3'd1: reg_rdata[N_COLS-1:0]   = mask_q;
      3'd2: reg_rdata[3:0]          = {abort_flag_q, tmo_flag_q, done_q, busy};
      3'd3: reg_rdata[CNT_W-1:0]    = cycles_q;
      3'd4: reg_rdata[CNT_W-1:0]    = tmo_q;
`ifdef KTH_SS_SEQ_LOOP_EN
      3'd5: reg_rdata[7:0]          = loop_q;
`endif
      default: reg_rdata = '0;
    endcase
  end
endmodule

// File: tb/tb_drra_launch_sequencer.sv
// Bench for drra_launch_sequencer: job-level reference model checked every cycle, directed scenarios, random traffic.
module tb_drra_launch_sequencer;
  localparam int N   = 2;
  localparam int CW  = 32;
  localparam int STR = 1;
`ifdef KTH_SS_SEQ_LOOP_EN
  localparam int LOOP_RD = 2;
  localparam int PASSES  = 3;
`else
  localparam int LOOP_RD = 0;
  localparam int PASSES  = 1;
`endif

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          we = 1'b0;
  logic [4:0]    addr = '0;
  logic [31:0]   wdata = '0;
  logic [31:0]   rdata;
  logic [N-1:0]  cs;
  logic [N-1:0]  ret = '0;
  logic          lock, irq, irqen;
  logic          chk_en = 1'b0;
  int            tests = 0;
  int            fails = 0;

  always #5 clk = ~clk;

  drra_launch_sequencer #(.N_COLS(N), .CNT_W(CW), .LAUNCH_STRIDE(STR)) dut (
    .clk_in(clk), .reset_int(rst), .reg_we(we), .reg_addr(addr), .reg_wdata(wdata),
    .reg_rdata(rdata), .col_start(cs), .col_ret(ret), .buf_lock(lock),
    .irq_3(irq), .irq_en_3(irqen)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Job-level model: a job is "active" with an offset o counted from the first launch cycle (o=1).
  int            m_mode = 0;   // 0 idle, 1 active, 2 completion cycle
  int            m_o = 0, m_left = 0;
  logic [N-1:0]  m_mask = '0, m_rs = '0;
  logic          m_irqen = 0, m_done = 0, m_to = 0, m_ab = 0, m_irq = 0;
  logic [CW-1:0] m_cyc = '0, m_tmo = '0;
  logic [7:0]    m_loop = '0;

  function automatic int launch_len();
    return 1 + ($countones(m_mask) - 1) * STR;
  endfunction

  function automatic logic [N-1:0] exp_cs();
    logic [N-1:0] v = '0;
    int rank = 0;
    for (int j = 0; j < N; j++) begin
      if (m_mask[j]) begin
        if (m_mode == 1 && m_o == 1 + rank * STR) v[j] = 1'b1;
        rank++;
      end
    end
    return v;
  endfunction

  function automatic logic [31:0] exp_rd(input logic [4:0] a);
    logic [31:0] v = '0;
    case (a[4:2])
      3'd0: v[2] = m_irqen;
      3'd1: v[N-1:0] = m_mask;
      3'd2: v[3:0] = {m_ab, m_to, m_done, m_mode != 0};
      3'd3: v = m_cyc;
      3'd4: v = m_tmo;
      3'd5: v = (LOOP_RD != 0) ? {24'd0, m_loop} : 32'd0;
      default: v = '0;
    endcase
    return v;
  endfunction

  always @(posedge clk) begin : model
    logic          ctrl, old_busy, n_irq;
    logic [CW-1:0] cyc_new;
    logic [N-1:0]  rs;
    if (rst) begin
      m_mode = 0; m_o = 0; m_left = 0; m_mask = '0; m_rs = '0;
      m_irqen = 0; m_done = 0; m_to = 0; m_ab = 0; m_irq = 0;
      m_cyc = '0; m_tmo = '0; m_loop = '0;
    end else begin
      ctrl     = we && addr[4:2] == 3'd0;
      old_busy = (m_mode != 0);
      n_irq    = m_irqen & (m_done | m_to | m_ab);
      if (we && addr[4:2] == 3'd2) begin
        if (wdata[1]) m_done = 0;
        if (wdata[2]) m_to = 0;
        if (wdata[3]) m_ab = 0;
      end
      if (m_mode == 1) begin
        cyc_new = (m_cyc == '1) ? m_cyc : m_cyc + 1;
        rs = m_rs | ret;
        if (ctrl && wdata[1]) begin
          m_ab = 1; m_mode = 0;
        end else if (m_tmo != 0 && cyc_new == m_tmo) begin
          m_to = 1; m_mode = 0;
        end else if (m_o > launch_len() && (rs & m_mask) == m_mask) begin
          if (m_left > 0) begin
            m_left--; m_o = 1; rs = '0;
          end else begin
            m_mode = 2;
          end
        end else begin
          m_o++;
        end
        m_rs = rs; m_cyc = cyc_new;
      end else if (m_mode == 2) begin
        m_done = 1; m_mode = 0;
      end else if (ctrl && wdata[0] && !wdata[1] && m_mask != 0) begin
        m_mode = 1; m_o = 1; m_cyc = '0; m_rs = '0;
        m_left = (LOOP_RD != 0) ? int'(m_loop) : 0;
      end
      if (ctrl) m_irqen = wdata[2];
      if (we && addr[4:2] == 3'd1 && !old_busy) m_mask = wdata[N-1:0];
      if (we && addr[4:2] == 3'd4) m_tmo = wdata;
      if (we && addr[4:2] == 3'd5 && LOOP_RD != 0) m_loop = wdata[7:0];
      m_irq = n_irq;
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("col_start", 32'(cs), 32'(exp_cs()));
      chk("buf_lock", 32'(lock), 32'(m_mode != 0));
      chk("irq_3", 32'(irq), 32'(m_irq));
      chk("irq_en_3", 32'(irqen), 32'(m_irqen));
      chk("reg_rdata", rdata, exp_rd(addr));
    end
  end

  task automatic step(input logic w, input logic [4:0] a, input logic [31:0] d, input logic [N-1:0] r);
    we = w; addr = a; wdata = d; ret = r;
    @(posedge clk); #1;
    we = 1'b0;
  endtask

  task automatic rd(input logic [4:0] a, input logic [31:0] e, input string nm);
    we = 1'b0; addr = a; #1;
    chk(nm, rdata, e);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, tests=%0d", tests);
    $fatal(1, "watchdog");
  end

  initial begin
    int pulses, pt;
    repeat (2) @(posedge clk);
    #1; rst = 1'b0; chk_en = 1'b1;

    // Reset state
    for (int a = 0; a <= 5; a++) rd(5'(a * 4), 32'd0, "reset_reg");
    chk("reset_cs", 32'(cs), 32'd0);
    chk("reset_lock", 32'(lock), 32'd0);
    chk("reset_irq", 32'(irq), 32'd0);

    // Two-column job, ret[0] pulse at cycle 5, ret[1] level from cycle 9
    step(1, 5'h04, 32'h3, '0);
    step(1, 5'h00, 32'h5, '0);
    for (int c = 1; c <= 13; c++) begin
      we = 0; addr = 5'h08; ret = {c >= 9, c == 5}; #1;
      if (c == 1) chk("s1_cs_c1", 32'(cs), 32'd1);
      if (c == 2) chk("s1_cs_c2", 32'(cs), 32'd2);
      if (c == 3) chk("s1_cs_c3", 32'(cs), 32'd0);
      if (c == 10) chk("s1_done_busy", 32'(lock), 32'd1);
      if (c == 11) begin
        chk("s1_idle", 32'(lock), 32'd0);
        chk("s1_status", rdata, 32'h2);
        chk("s1_irq_c11", 32'(irq), 32'd0);
      end
      if (c == 12) chk("s1_irq_c12", 32'(irq), 32'd1);
      @(posedge clk); #1;
    end
    ret = '0;
    rd(5'h0C, 32'd9, "s1_cycles");
    step(1, 5'h08, 32'hE, '0);

    // Timeout of 20 cycles with no ret
    step(1, 5'h10, 32'd20, '0);
    step(1, 5'h04, 32'h1, '0);
    step(1, 5'h00, 32'h5, '0);
    for (int c = 1; c <= 22; c++) begin
      we = 0; addr = 5'h08; #1;
      if (c == 20) chk("s2_busy_c20", 32'(lock), 32'd1);
      if (c == 21) begin
        chk("s2_lock_c21", 32'(lock), 32'd0);
        chk("s2_status", rdata, 32'h4);
      end
      @(posedge clk); #1;
    end
    rd(5'h0C, 32'd20, "s2_cycles");
    step(1, 5'h10, 32'd0, '0);
    step(1, 5'h08, 32'hE, '0);

    // Abort in the first launch cycle suppresses column 1
    step(1, 5'h04, 32'h3, '0);
    step(1, 5'h00, 32'h1, '0);
    step(1, 5'h00, 32'h2, '0);
    for (int c = 2; c <= 6; c++) begin
      we = 0; addr = 5'h08; #1;
      chk("s3_no_cs", 32'(cs), 32'd0);
      if (c == 2) chk("s3_lock", 32'(lock), 32'd0);
      @(posedge clk); #1;
    end
    rd(5'h08, 32'h8, "s3_status");
    step(1, 5'h08, 32'hE, '0);

    // Start while busy, W1C colliding with DONE, zero-mask start
    step(1, 5'h00, 32'h1, '0);
    step(0, 5'h08, 32'h0, '0);
    step(1, 5'h00, 32'h1, '0);
    step(0, 5'h08, 32'h0, 2'b11);
    chk("s4_done_state", 32'(lock), 32'd1);
    step(1, 5'h08, 32'hE, '0);
    chk("s4_no_relaunch", 32'(lock), 32'd0);
    rd(5'h08, 32'h2, "s4_done_kept");
    step(1, 5'h08, 32'hE, '0);
    step(1, 5'h04, 32'h0, '0);
    step(1, 5'h00, 32'h1, '0);
    chk("s4_zero_mask_lock", 32'(lock), 32'd0);
    chk("s4_zero_mask_cs", 32'(cs), 32'd0);

    // Loop passes: ret returns 3 cycles after each launch pulse
    step(1, 5'h04, 32'h1, '0);
    step(1, 5'h14, 32'h2, '0);
    rd(5'h14, 32'(LOOP_RD), "s5_loop_rd");
    step(1, 5'h00, 32'h1, '0);
    pulses = 0; pt = -10;
    for (int c = 1; c <= 60; c++) begin
      we = 0; addr = 5'h08; ret = (c == pt + 3) ? 2'b01 : 2'b00; #1;
      if (cs[0]) begin pulses++; pt = c; end
      if (c > 1 && !lock) break;
      @(posedge clk); #1;
    end
    ret = '0;
    chk("s5_ended", 32'(lock), 32'd0);
    chk("s5_passes", 32'(pulses), 32'(PASSES));
    rd(5'h08, 32'h2, "s5_status");
    step(1, 5'h14, 32'h0, '0);

    // Random traffic against the model
    for (int i = 0; i < 4000; i++) begin
      int k, wsel;
      k = $urandom_range(0, 199);
      wsel = $urandom_range(0, 7);
      rst = (k == 0);
      we = (k >= 1 && k < 60);
      if ($urandom_range(0, 2) == 0) wsel = 0;
      addr = {3'(wsel), 2'($urandom_range(0, 3))};
      case (wsel)
        0: wdata = 32'($urandom_range(0, 7));
        4: wdata = 32'($urandom_range(0, 40));
        5: wdata = 32'($urandom_range(0, 3));
        default: wdata = $urandom;
      endcase
      ret = ($urandom_range(0, 5) == 0) ? N'($urandom) : '0;
      @(posedge clk); #1;
    end
    rst = 1'b0; we = 1'b0; ret = '0;
    repeat (3) @(posedge clk);
    #1;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
